stack_memory_stage: RTL and testbench
=====================================

# stack_memory_stage

Parametrised MEM stage of the five-stage pipeline, sitting between the EX/MEM and MEM/WB buffers. Owns a word-addressed data memory and the stack pointer, and executes loads, stores, push and pop. Runs a multi-cycle interrupt-entry push sequence (PC high, PC low, flags) and a matching return-from-interrupt pop sequence, stalling upstream while either runs. Registers results into the MEM/WB buffer.

## Interface
- DATA_W, 16, data word width
- PC_W, 32, PC width; must equal 2*DATA_W
- ADDR_W, 12, memory address width; depth 2^ADDR_W words; SP width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX/MEM entry valid
- ex_alu_result  in  DATA_W  ALU result, passed through
- ex_rsrc  in  DATA_W  load address / store and push data
- ex_rdst  in  DATA_W  store address
- ex_rdst_addr  in  3  destination register index
- ex_mem_read, ex_mem_write, ex_push, ex_pop, ex_wb  in  1 each  control
- int_req  in  1  start interrupt-entry sequence
- rti_req  in  1  start return sequence
- pc  in  PC_W  PC to save on interrupt
- flags  in  DATA_W  flag register to save on interrupt
- stall  out  1  upstream must hold EX/MEM entry
- mw_valid, mw_mem_read, mw_wb  out  1 each  MEM/WB control
- mw_data  out  DATA_W  word read by load/pop, else 0
- mw_alu_result  out  DATA_W  registered ex_alu_result
- mw_rdst_addr  out  3  registered ex_rdst_addr
- rti_pc  out  PC_W  restored PC
- rti_flags  out  DATA_W  restored flags
- rti_done  out  1  one-cycle pulse, rti_pc/rti_flags valid
- sp  out  ADDR_W  current stack pointer
- stack_err  out  1  sticky stack bounds error

## Operation
- States: IDLE, INT2, INT3, RTI2, RTI3.
- Memory address is the low ADDR_W bits of the source operand. Write is synchronous. Read is asynchronous and captured into mw_data.
- Stack: push writes mem[sp] and sets sp=sp-1. Pop reads mem[sp+1] and sets sp=sp+1. Stack grows downward from all-ones.
- IDLE with int_req and rti_req both low, ex_valid=1:
  - load reads mem[ex_rsrc].
  - store writes ex_rsrc to mem[ex_rdst].
  - push writes ex_rsrc.
  - pop reads as above.
- Within an EX/MEM entry:
  - push and pop both set: no stack access, sp unchanged.
  - read and write both set: write only, mw_data=0.
- IDLE with int_req (priority over rti_req):
  - Capture pc and flags internally; later input changes are ignored.
  - Push pc[PC_W-1:DATA_W], then go to INT2.
  - INT2 pushes pc[DATA_W-1:0] and goes to INT3.
  - INT3 pushes flags and goes to IDLE.
- IDLE with rti_req:
  - Pop into rti_flags, then go to RTI2.
  - RTI2 pops into rti_pc low half and goes to RTI3.
  - RTI3 pops into rti_pc high half and goes to IDLE.
  - rti_done pulses on the following cycle.
- stall is combinational: (state!=IDLE) | int_req | rti_req. The EX/MEM entry is not consumed while stall=1.
- During sequences, mw_valid=0 and the MEM/WB controls are 0 (bubble).
- ex_valid=0 in IDLE gives a bubble with no memory or sp change.

## Timing
- Reset: sp=all-ones, state=IDLE, every mw_* output=0, rti_pc=0, rti_flags=0, rti_done=0, stack_err=0. Memory contents are not reset.
- Reset asserted mid-sequence aborts immediately to the reset values; the partially pushed words remain in memory.
- MEM/WB outputs have 1-cycle latency: the entry accepted at edge N appears after edge N.
- Memory write and sp update take effect at the same edge. A pop on the cycle after a push returns the pushed word.
- Interrupt entry stalls for 3 cycles; the held entry is consumed on the 4th.
- RTI stalls for 3 cycles; rti_done is high in the 4th cycle.
- rti_pc and rti_flags hold their values until the next RTI.
- sp wraps modulo 2^ADDR_W unless STACK_BOUNDS_CHK_EN is defined.

## Configuration
- STACK_BOUNDS_CHK_EN defined:
  - Push with sp==0 is overflow; pop with sp==all-ones is underflow.
  - The offending access is suppressed: no write, sp unchanged, mw_data=0.
  - stack_err sets and stays set until reset.
  - Running sequences continue with the remaining words.
- Not defined: no checks, sp wraps, stack_err tied 0.

## Test plan
- Reset, then push ex_rsrc=0x1234 and pop -> sp 0xFFF→0xFFE→0xFFF, and mw_data=0x1234 one cycle after the pop.
- Store ex_rsrc=0xBEEF to ex_rdst=0x0010, then load ex_rsrc=0x0010 -> mw_data=0xBEEF, mw_mem_read=1, mw_rdst_addr passed through.
- int_req with pc=0x0001_0040 and flags=0x0005 -> stall for 3 cycles, mem[0xFFF]=0x0001, mem[0xFFE]=0x0040, mem[0xFFD]=0x0005, sp=0xFFC, mw_valid=0 throughout.
- rti_req immediately after the interrupt sequence -> rti_flags=0x0005, rti_pc=0x0001_0040, rti_done pulses in cycle 4, sp=0xFFF.
- rst_n low during INT2 -> all outputs return to reset values at once, stall drops, sp=0xFFF.
- With STACK_BOUNDS_CHK_EN: pop at sp=0xFFF -> stack_err=1 sticky, sp unchanged. Without the macro: the same pop wraps sp to 0x000.

Source files
------------

// File: rtl/stack_memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : stack_memory_stage
// Description : MEM stage of the five-stage pipeline. Owns the word-addressed
//               data memory and the stack pointer. Executes load, store, push
//               and pop. Runs the interrupt-entry push sequence (PC high,
//               PC low, flags) and the return-from-interrupt pop sequence,
//               and stalls upstream while either is running. Results are
//               registered into the MEM/WB buffer.
// Options     : STACK_BOUNDS_CHK_EN - when defined, a push at sp==0 or a pop
//               at sp==all-ones is suppressed and sets the sticky stack_err.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_memory_stage #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_rsrc,
  input  logic [DATA_W-1:0] ex_rdst,
  input  logic [2:0]        ex_rdst_addr,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_push,
  input  logic              ex_pop,
  input  logic              ex_wb,
  input  logic              int_req,
  input  logic              rti_req,
  input  logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] flags,
  output logic              stall,
  output logic              mw_valid,
  output logic              mw_mem_read,
  output logic              mw_wb,
  output logic [DATA_W-1:0] mw_data,
  output logic [DATA_W-1:0] mw_alu_result,
  output logic [2:0]        mw_rdst_addr,
  output logic [PC_W-1:0]   rti_pc,
  output logic [DATA_W-1:0] rti_flags,
  output logic              rti_done,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_err
);

  localparam int DEPTH = 1 << ADDR_W;

`ifdef STACK_BOUNDS_CHK_EN
  localparam bit BOUNDS_CHK = 1'b1;
`else
  localparam bit BOUNDS_CHK = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INT2 = 3'd1,
    S_INT3 = 3'd2,
    S_RTI2 = 3'd3,
    S_RTI3 = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  sp_q, sp_d;
  logic               mw_valid_q, mw_valid_d;
  logic               mw_mem_read_q, mw_mem_read_d;
  logic               mw_wb_q, mw_wb_d;
  logic [DATA_W-1:0]  mw_data_q, mw_data_d;
  logic [DATA_W-1:0]  mw_alu_result_q, mw_alu_result_d;
  logic [2:0]         mw_rdst_addr_q, mw_rdst_addr_d;
  logic [PC_W-1:0]    rti_pc_q, rti_pc_d;
  logic [DATA_W-1:0]  rti_flags_q, rti_flags_d;
  logic               rti_done_q, rti_done_d;
  logic               stack_err_q, stack_err_d;
  logic [DATA_W-1:0]  pc_lo_q, pc_lo_d;
  logic [DATA_W-1:0]  flags_sv_q, flags_sv_d;

  logic [DATA_W-1:0]  mem_q [0:DEPTH-1];

  logic               push_req, pop_req;
  logic [DATA_W-1:0]  push_data;
  logic               push_ok, pop_ok;
  logic               overflow, underflow;
  logic               store_we;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [ADDR_W-1:0]  sp_plus1, sp_minus1;
  logic [DATA_W-1:0]  pop_rdata, load_rdata;
  logic               unused_rdst_hi;

  // Only the low ADDR_W bits of the store address select a word.
  assign unused_rdst_hi = ^ex_rdst[DATA_W-1:ADDR_W];

  assign sp_plus1   = sp_q + 1'b1;
  assign sp_minus1  = sp_q - 1'b1;
  assign pop_rdata  = mem_q[sp_plus1];
  assign load_rdata = mem_q[ex_rsrc[ADDR_W-1:0]];

  // Decode which stack access (if any) this cycle requests.
  always_comb begin
    push_req  = 1'b0;
    pop_req   = 1'b0;
    push_data = '0;
    store_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (int_req) begin
          push_req  = 1'b1;
          push_data = pc[PC_W-1:DATA_W];
        end else if (rti_req) begin
          pop_req = 1'b1;
        end else if (ex_valid) begin
          store_we  = ex_mem_write;
          // Push+pop together cancel; a store owns the single write port.
          push_req  = ex_push & ~ex_pop & ~ex_mem_write;
          pop_req   = ex_pop & ~ex_push;
          push_data = ex_rsrc;
        end
      end
      S_INT2: begin
        push_req  = 1'b1;
        push_data = pc_lo_q;
      end
      S_INT3: begin
        push_req  = 1'b1;
        push_data = flags_sv_q;
      end
      S_RTI2, S_RTI3: pop_req = 1'b1;
      default: ;
    endcase
  end

  assign overflow  = BOUNDS_CHK & push_req & (sp_q == '0);
  assign underflow = BOUNDS_CHK & pop_req & (sp_q == '1);
  assign push_ok   = push_req & ~overflow;
  assign pop_ok    = pop_req & ~underflow;

  // Memory write port: stack pushes and ordinary stores never coincide.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (push_ok) begin
      mem_we    = rst_n;
      mem_waddr = sp_q;
      mem_wdata = push_data;
    end else if (store_we) begin
      mem_we    = rst_n;
      mem_waddr = ex_rdst[ADDR_W-1:0];
      mem_wdata = ex_rsrc;
    end
  end

  // Next-state, stack pointer and MEM/WB buffer contents.
  always_comb begin
    state_d         = state_q;
    sp_d            = sp_q;
    mw_valid_d      = 1'b0;
    mw_mem_read_d   = 1'b0;
    mw_wb_d         = 1'b0;
    mw_data_d       = '0;
    mw_alu_result_d = '0;
    mw_rdst_addr_d  = '0;
    rti_pc_d        = rti_pc_q;
    rti_flags_d     = rti_flags_q;
    rti_done_d      = 1'b0;
    stack_err_d     = stack_err_q | overflow | underflow;
    pc_lo_d         = pc_lo_q;
    flags_sv_d      = flags_sv_q;

    if (push_ok) sp_d = sp_minus1;
    if (pop_ok)  sp_d = sp_plus1;

    case (state_q)
      S_IDLE: begin
        if (int_req) begin
          pc_lo_d    = pc[DATA_W-1:0];
          flags_sv_d = flags;
          state_d    = S_INT2;
        end else if (rti_req) begin
          if (pop_ok) rti_flags_d = pop_rdata;
          state_d = S_RTI2;
        end else if (ex_valid) begin
          mw_valid_d      = 1'b1;
          mw_mem_read_d   = ex_mem_read;
          mw_wb_d         = ex_wb;
          mw_alu_result_d = ex_alu_result;
          mw_rdst_addr_d  = ex_rdst_addr;
          if (ex_mem_write)     mw_data_d = '0;
          else if (ex_mem_read) mw_data_d = load_rdata;
          else if (pop_ok)      mw_data_d = pop_rdata;
        end
      end
      S_INT2: state_d = S_INT3;
      S_INT3: state_d = S_IDLE;
      S_RTI2: begin
        if (pop_ok) rti_pc_d[DATA_W-1:0] = pop_rdata;
        state_d = S_RTI3;
      end
      S_RTI3: begin
        if (pop_ok) rti_pc_d[PC_W-1:DATA_W] = pop_rdata;
        rti_done_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pipeline state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      sp_q            <= '1;
      mw_valid_q      <= 1'b0;
      mw_mem_read_q   <= 1'b0;
      mw_wb_q         <= 1'b0;
      mw_data_q       <= '0;
      mw_alu_result_q <= '0;
      mw_rdst_addr_q  <= '0;
      rti_pc_q        <= '0;
      rti_flags_q     <= '0;
      rti_done_q      <= 1'b0;
      stack_err_q     <= 1'b0;
      pc_lo_q         <= '0;
      flags_sv_q      <= '0;
    end else begin
      state_q         <= state_d;
      sp_q            <= sp_d;
      mw_valid_q      <= mw_valid_d;
      mw_mem_read_q   <= mw_mem_read_d;
      mw_wb_q         <= mw_wb_d;
      mw_data_q       <= mw_data_d;
      mw_alu_result_q <= mw_alu_result_d;
      mw_rdst_addr_q  <= mw_rdst_addr_d;
      rti_pc_q        <= rti_pc_d;
      rti_flags_q     <= rti_flags_d;
      rti_done_q      <= rti_done_d;
      stack_err_q     <= stack_err_d;
      pc_lo_q         <= pc_lo_d;
      flags_sv_q      <= flags_sv_d;
    end
  end

  // Data memory: synchronous write, contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign stall         = (state_q != S_IDLE) | int_req | rti_req;
  assign mw_valid      = mw_valid_q;
  assign mw_mem_read   = mw_mem_read_q;
  assign mw_wb         = mw_wb_q;
  assign mw_data       = mw_data_q;
  assign mw_alu_result = mw_alu_result_q;
  assign mw_rdst_addr  = mw_rdst_addr_q;
  assign rti_pc        = rti_pc_q;
  assign rti_flags     = rti_flags_q;
  assign rti_done      = rti_done_q;
  assign sp            = sp_q;
  assign stack_err     = stack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_memory_stage
// Description : Directed bench for stack_memory_stage: push/pop, load/store,
//               interrupt entry, return from interrupt, mid-sequence reset
//               and stack bounds behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_memory_stage;

  localparam int DATA_W = 16;
  localparam int PC_W   = 32;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_alu_result;
  logic [DATA_W-1:0] ex_rsrc;
  logic [DATA_W-1:0] ex_rdst;
  logic [2:0]        ex_rdst_addr;
  logic              ex_mem_read, ex_mem_write, ex_push, ex_pop, ex_wb;
  logic              int_req, rti_req;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] flags;
  logic              stall;
  logic              mw_valid, mw_mem_read, mw_wb;
  logic [DATA_W-1:0] mw_data, mw_alu_result;
  logic [2:0]        mw_rdst_addr;
  logic [PC_W-1:0]   rti_pc;
  logic [DATA_W-1:0] rti_flags;
  logic              rti_done;
  logic [ADDR_W-1:0] sp;
  logic              stack_err;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  stack_memory_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_rsrc(ex_rsrc),
    .ex_rdst(ex_rdst), .ex_rdst_addr(ex_rdst_addr),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_push(ex_push), .ex_pop(ex_pop), .ex_wb(ex_wb),
    .int_req(int_req), .rti_req(rti_req), .pc(pc), .flags(flags),
    .stall(stall), .mw_valid(mw_valid), .mw_mem_read(mw_mem_read), .mw_wb(mw_wb),
    .mw_data(mw_data), .mw_alu_result(mw_alu_result), .mw_rdst_addr(mw_rdst_addr),
    .rti_pc(rti_pc), .rti_flags(rti_flags), .rti_done(rti_done),
    .sp(sp), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_alu_result = '0; ex_rsrc = '0; ex_rdst = '0; ex_rdst_addr = '0;
    ex_mem_read = 0; ex_mem_write = 0; ex_push = 0; ex_pop = 0; ex_wb = 0;
  endtask

  initial begin
    clear_ex();
    int_req = 0; rti_req = 0; pc = '0; flags = '0;
    rst_n = 0;
    step(); step();
    chk("rst_sp", 32'(sp), 32'hFFF);
    chk("rst_mw_valid", 32'(mw_valid), 0);
    chk("rst_mw_data", 32'(mw_data), 0);
    chk("rst_rti_done", 32'(rti_done), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_stack_err", 32'(stack_err), 0);
    rst_n = 1;

    // push 0x1234
    ex_valid = 1; ex_push = 1; ex_rsrc = 16'h1234;
    step();
    chk("push_sp", 32'(sp), 32'hFFE);
    chk("push_mw_valid", 32'(mw_valid), 1);
    chk("push_mw_data", 32'(mw_data), 0);

    // pop returns pushed word
    clear_ex(); ex_valid = 1; ex_pop = 1; ex_wb = 1; ex_rdst_addr = 3'd3;
    step();
    chk("pop_sp", 32'(sp), 32'hFFF);
    chk("pop_mw_data", 32'(mw_data), 32'h1234);
    chk("pop_rdst_addr", 32'(mw_rdst_addr), 3);
    chk("pop_mw_wb", 32'(mw_wb), 1);

    // store 0xBEEF to 0x0010
    clear_ex(); ex_valid = 1; ex_mem_write = 1; ex_rsrc = 16'hBEEF; ex_rdst = 16'h0010;
    step();
    chk("store_mw_data", 32'(mw_data), 0);
    chk("store_sp", 32'(sp), 32'hFFF);

    // load from 0x0010
    clear_ex(); ex_valid = 1; ex_mem_read = 1; ex_rsrc = 16'h0010;
    ex_rdst_addr = 3'd5; ex_alu_result = 16'hAAAA; ex_wb = 1;
    step();
    chk("load_mw_data", 32'(mw_data), 32'hBEEF);
    chk("load_mw_mem_read", 32'(mw_mem_read), 1);
    chk("load_rdst_addr", 32'(mw_rdst_addr), 5);
    chk("load_alu_result", 32'(mw_alu_result), 32'hAAAA);

    // read+write together: write only, data 0
    clear_ex(); ex_valid = 1; ex_mem_read = 1; ex_mem_write = 1;
    ex_rsrc = 16'h7777; ex_rdst = 16'h0010;
    step();
    chk("rw_mw_data", 32'(mw_data), 0);
    clear_ex(); ex_valid = 1; ex_mem_read = 1; ex_rsrc = 16'h0010;
    step();
    chk("rw_written", 32'(mw_data), 32'h7777);

    // push+pop together: no stack access
    clear_ex(); ex_valid = 1; ex_push = 1; ex_pop = 1; ex_rsrc = 16'h4444;
    step();
    chk("pushpop_sp", 32'(sp), 32'hFFF);
    chk("pushpop_mw_data", 32'(mw_data), 0);

    // bubble
    clear_ex(); ex_push = 1; ex_rsrc = 16'h5555;
    step();
    chk("bubble_sp", 32'(sp), 32'hFFF);
    chk("bubble_mw_valid", 32'(mw_valid), 0);

    // interrupt entry with a held ALU entry
    clear_ex(); ex_valid = 1; ex_wb = 1; ex_alu_result = 16'h0C0C; ex_rdst_addr = 3'd6;
    int_req = 1; pc = 32'h0001_0040; flags = 16'h0005;
    #1;
    chk("int_stall_c1", 32'(stall), 1);
    step();
    int_req = 0; pc = 32'hFFFF_FFFF; flags = 16'hFFFF;
    #1;
    chk("int_sp_c1", 32'(sp), 32'hFFE);
    chk("int_mw_valid_c1", 32'(mw_valid), 0);
    chk("int_stall_c2", 32'(stall), 1);
    step();
    chk("int_sp_c2", 32'(sp), 32'hFFD);
    chk("int_mw_valid_c2", 32'(mw_valid), 0);
    chk("int_stall_c3", 32'(stall), 1);
    step();
    chk("int_sp_c3", 32'(sp), 32'hFFC);
    chk("int_mw_valid_c3", 32'(mw_valid), 0);
    chk("int_stall_c4", 32'(stall), 0);
    step();
    chk("held_mw_valid", 32'(mw_valid), 1);
    chk("held_alu_result", 32'(mw_alu_result), 32'h0C0C);
    chk("held_rdst_addr", 32'(mw_rdst_addr), 6);

    // memory contents of the interrupt frame
    clear_ex(); ex_valid = 1; ex_mem_read = 1; ex_rsrc = 16'h0FFF;
    step();
    chk("frame_fff", 32'(mw_data), 32'h0001);
    ex_rsrc = 16'h0FFE;
    step();
    chk("frame_ffe", 32'(mw_data), 32'h0040);
    ex_rsrc = 16'h0FFD;
    step();
    chk("frame_ffd", 32'(mw_data), 32'h0005);

    // return from interrupt
    clear_ex(); rti_req = 1;
    #1;
    chk("rti_stall_c1", 32'(stall), 1);
    step();
    rti_req = 0;
    #1;
    chk("rti_sp_c1", 32'(sp), 32'hFFD);
    chk("rti_flags_c1", 32'(rti_flags), 32'h0005);
    chk("rti_done_c2", 32'(rti_done), 0);
    chk("rti_stall_c2", 32'(stall), 1);
    step();
    chk("rti_sp_c2", 32'(sp), 32'hFFE);
    chk("rti_done_c3", 32'(rti_done), 0);
    step();
    chk("rti_sp_c3", 32'(sp), 32'hFFF);
    chk("rti_done_c4", 32'(rti_done), 1);
    chk("rti_pc", rti_pc, 32'h0001_0040);
    chk("rti_flags", 32'(rti_flags), 32'h0005);
    chk("rti_stall_c4", 32'(stall), 0);
    chk("rti_mw_valid", 32'(mw_valid), 0);
    step();
    chk("rti_done_c5", 32'(rti_done), 0);
    chk("rti_pc_hold", rti_pc, 32'h0001_0040);

    // reset during INT2
    int_req = 1; pc = 32'h1234_5678; flags = 16'h0009;
    step();
    int_req = 0;
    #1;
    chk("abort_sp_int2", 32'(sp), 32'hFFE);
    chk("abort_stall_int2", 32'(stall), 1);
    rst_n = 0;
    #1;
    chk("abort_stall", 32'(stall), 0);
    chk("abort_sp", 32'(sp), 32'hFFF);
    chk("abort_rti_pc", rti_pc, 0);
    chk("abort_rti_flags", 32'(rti_flags), 0);
    step();
    rst_n = 1;
    step();
    chk("abort_stall_after", 32'(stall), 0);
    chk("abort_sp_after", 32'(sp), 32'hFFF);
    clear_ex(); ex_valid = 1; ex_mem_read = 1; ex_rsrc = 16'h0FFF;
    step();
    chk("abort_partial_word", 32'(mw_data), 32'h1234);

    // pop with empty stack
    clear_ex(); ex_valid = 1; ex_pop = 1;
    step();
`ifdef STACK_BOUNDS_CHK_EN
    chk("underflow_sp", 32'(sp), 32'hFFF);
    chk("underflow_err", 32'(stack_err), 1);
    chk("underflow_mw_data", 32'(mw_data), 0);
    clear_ex();
    step();
    chk("underflow_err_sticky", 32'(stack_err), 1);
`else
    chk("wrap_sp", 32'(sp), 32'h000);
    chk("wrap_err", 32'(stack_err), 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
